// File: rtl/mc_pkg.sv
// Shared multicycle-processor constants: control-state codes and the opcodes
// recognised by the control-state sequencer, decoder bench and datapath control.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ERR       = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    localparam int         OPC_W    = 6;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state and instruction-retire logic for the multicycle
// control-state sequencer; holds no state of its own.
module mc_next_state
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [3:0]      i_state,
    input  logic [OP_W-1:0] i_opcode,
    input  logic [OP_W-1:0] i_latched_op,
    input  logic            i_mem_ready,
    output logic [3:0]      o_next,
    output logic            o_instr_done
);

    localparam logic [OP_W-1:0] L_RTYPE = OP_W'(OP_RTYPE);
    localparam logic [OP_W-1:0] L_LW    = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] L_SW    = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] L_BEQ   = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] L_J     = OP_W'(OP_J);
    localparam logic [OP_W-1:0] L_ADDI  = OP_W'(OP_ADDI);
    localparam logic [OP_W-1:0] L_HALT  = OP_W'(OP_HALT);

    always_comb begin
        o_next       = S_FETCH;
        o_instr_done = 1'b0;
        case (i_state)
            S_FETCH:     o_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (i_opcode == L_RTYPE)                         o_next = S_EXEC;
                else if (i_opcode == L_LW || i_opcode == L_SW)   o_next = S_MEM_ADDR;
                else if (i_opcode == L_BEQ)                      o_next = S_BRANCH;
                else if (i_opcode == L_J)                        o_next = S_JUMP;
                else if (i_opcode == L_ADDI)                     o_next = S_ADDI_EX;
                else if (i_opcode == L_HALT)                     o_next = S_HALT;
                else                                             o_next = S_ERR;
            end
            // Only LW/SW reach MEM_ADDR, so the latched copy is trusted here.
            S_MEM_ADDR: begin
                if (i_latched_op == L_LW)      o_next = S_MEM_READ;
                else if (i_latched_op == L_SW) o_next = S_MEM_WRITE;
                else                           o_next = S_ERR;
            end
            S_MEM_READ:  o_next = i_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                o_next       = i_mem_ready ? S_FETCH : S_MEM_WRITE;
                o_instr_done = i_mem_ready;
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                o_next       = S_FETCH;
                o_instr_done = 1'b1;
            end
            S_EXEC:      o_next = S_ALU_WB;
            S_ADDI_EX:   o_next = S_ADDI_WB;
            S_ERR:       o_next = S_ERR;
            S_HALT:      o_next = S_HALT;
            default:     o_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_state_seq.sv
// Multicycle control-state sequencer feeding the mux16 state decoder.
// Define MC_SEQ_PERF_CNT_EN to add the cyc_cnt/instr_cnt performance counters.
module mc_state_seq
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic [3:0]      state,
    output logic            instr_done,
    output logic            halted,
    output logic            err
`ifdef MC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]     cyc_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    logic [3:0]      r_state;
    logic [OP_W-1:0] r_opcode;
    logic            r_instr_done;
    logic            r_halted;
    logic            r_err;
    logic [3:0]      w_next;
    logic            w_instr_done;

    mc_next_state #(
        .OP_W (OP_W)
    ) u_next_state (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_latched_op (r_opcode),
        .i_mem_ready  (mem_ready),
        .o_next       (w_next),
        .o_instr_done (w_instr_done)
    );

    // Status flags are derived from the next state so they rise with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_opcode     <= '0;
            r_instr_done <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
        end else if (en) begin
            r_state      <= w_next;
            r_instr_done <= w_instr_done;
            r_halted     <= (w_next == S_HALT);
            r_err        <= (w_next == S_ERR);
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    assign state      = r_state;
    assign instr_done = r_instr_done;
    assign halted     = r_halted;
    assign err        = r_err;

`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else if (en) begin
            if (r_state != S_HALT && r_state != S_ERR) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if (w_instr_done) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_state_seq.sv
// Scoreboard bench for mc_state_seq: directed per-cycle vectors push expected
// outputs; a monitor pops and compares one entry after every rising edge.
module tb_mc_state_seq;
    import mc_pkg::*;

    typedef struct {
        logic [3:0] st;
        logic       done;
        logic       halt;
        logic       er;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] state;
    logic       instr_done;
    logic       halted;
    logic       err;
`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] instr_cnt;
`endif

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    mc_state_seq #(
        .OP_W (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .state      (state),
        .instr_done (instr_done),
        .halted     (halted),
        .err        (err)
`ifdef MC_SEQ_PERF_CNT_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] expSt,
                               input logic expDone, input logic expHalt, input logic expErr);
        nChecks++;
        if (state !== expSt || instr_done !== expDone || halted !== expHalt || err !== expErr) begin
            nFails++;
            $display("[TB] FAIL %s: got state=%0d done=%0b halted=%0b err=%0b, expected state=%0d done=%0b halted=%0b err=%0b",
                     name, state, instr_done, halted, err, expSt, expDone, expHalt, expErr);
        end
    endtask

    // Called at a falling edge: drives inputs for the next rising edge and
    // records what the outputs must be just after that edge.
    task automatic applyStimulus(input logic e, input logic [5:0] op, input logic mr,
                                 input logic [3:0] st, input logic dn, input logic hl,
                                 input logic er, input string tag);
        exp_t x;
        en        = e;
        opcode    = op;
        mem_ready = mr;
        x.st = st; x.done = dn; x.halt = hl; x.er = er; x.tag = tag;
        expQ.push_back(x);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse: outputs are checked before any clock edge.
    task automatic resetDut(input string tag);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 checkOutput(tag, S_FETCH, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput(x.tag, x.st, x.done, x.halt, x.er);
            end
        end
    end

    initial begin : stimulus
        en        = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        resetDut("reset_initial");

        // R, BEQ, J back to back: 4 + 3 + 3 cycles, three retirements
        applyStimulus(1, OP_RTYPE, 1, S_FETCH+1, 0, 0, 0, "r_fetch");
        applyStimulus(1, OP_RTYPE, 1, S_EXEC,     0, 0, 0, "r_decode");
        applyStimulus(1, OP_RTYPE, 1, S_ALU_WB,   0, 0, 0, "r_exec");
        applyStimulus(1, OP_RTYPE, 1, S_FETCH,    1, 0, 0, "r_done");
        applyStimulus(1, OP_BEQ,   1, S_DECODE,   0, 0, 0, "beq_fetch");
        applyStimulus(1, OP_BEQ,   1, S_BRANCH,   0, 0, 0, "beq_decode");
        applyStimulus(1, OP_BEQ,   1, S_FETCH,    1, 0, 0, "beq_done");
        applyStimulus(1, OP_J,     1, S_DECODE,   0, 0, 0, "j_fetch");
        applyStimulus(1, OP_J,     1, S_JUMP,     0, 0, 0, "j_decode");
        applyStimulus(1, OP_J,     1, S_FETCH,    1, 0, 0, "j_done");
`ifdef MC_SEQ_PERF_CNT_EN
        nChecks++;
        if (instr_cnt !== 32'd3) begin
            nFails++;
            $display("[TB] FAIL instr_cnt: got %0d, expected 3", instr_cnt);
        end
        nChecks++;
        if (cyc_cnt !== 32'd10) begin
            nFails++;
            $display("[TB] FAIL cyc_cnt: got %0d, expected 10", cyc_cnt);
        end
`endif

        // LW with memory always ready, then FETCH waiting on memory
        applyStimulus(1, OP_LW, 1, S_DECODE,   0, 0, 0, "lw_fetch");
        applyStimulus(1, OP_LW, 1, S_MEM_ADDR, 0, 0, 0, "lw_decode");
        applyStimulus(1, OP_LW, 1, S_MEM_READ, 0, 0, 0, "lw_addr");
        applyStimulus(1, OP_LW, 1, S_MEM_WB,   0, 0, 0, "lw_read");
        applyStimulus(1, OP_LW, 1, S_FETCH,    1, 0, 0, "lw_done");
        applyStimulus(1, OP_LW, 0, S_FETCH,    0, 0, 0, "fetch_wait");

        // SW with three stall cycles; live opcode changed after DECODE
        applyStimulus(1, OP_SW, 1, S_DECODE,    0, 0, 0, "sw_fetch");
        applyStimulus(1, OP_SW, 1, S_MEM_ADDR,  0, 0, 0, "sw_decode");
        applyStimulus(1, OP_LW, 1, S_MEM_WRITE, 0, 0, 0, "sw_latched_op");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, OP_LW, 0, S_MEM_WRITE, 0, 0, 0, "sw_stall");
        applyStimulus(1, OP_LW, 1, S_FETCH,     1, 0, 0, "sw_done");

        // R held by en=0 in EXEC with a HALT opcode on the bus, then ADDI
        applyStimulus(1, OP_RTYPE, 1, S_DECODE, 0, 0, 0, "en_fetch");
        applyStimulus(1, OP_RTYPE, 1, S_EXEC,   0, 0, 0, "en_decode");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, OP_HALT, 1'(i), S_EXEC, 0, 0, 0, "en_hold");
        applyStimulus(1, OP_HALT, 1, S_ALU_WB,  0, 0, 0, "en_resume");
        applyStimulus(1, OP_ADDI, 1, S_FETCH,   1, 0, 0, "en_done");
        applyStimulus(1, OP_ADDI, 1, S_DECODE,  0, 0, 0, "addi_fetch");
        applyStimulus(1, OP_ADDI, 1, S_ADDI_EX, 0, 0, 0, "addi_decode");
        applyStimulus(1, OP_ADDI, 1, S_ADDI_WB, 0, 0, 0, "addi_ex");
        applyStimulus(1, OP_ADDI, 1, S_FETCH,   1, 0, 0, "addi_done");

        // LW stalled in MEM_READ; a ready pulse under en=0 is not remembered
        applyStimulus(1, OP_LW, 1, S_DECODE,   0, 0, 0, "lwr_fetch");
        applyStimulus(1, OP_LW, 1, S_MEM_ADDR, 0, 0, 0, "lwr_decode");
        applyStimulus(1, OP_LW, 0, S_MEM_READ, 0, 0, 0, "lwr_addr");
        applyStimulus(0, OP_LW, 1, S_MEM_READ, 0, 0, 0, "lwr_en_low_ready");
        applyStimulus(1, OP_LW, 0, S_MEM_READ, 0, 0, 0, "lwr_no_latch");
        resetDut("reset_mid_read");

        // Illegal opcode: ERR is absorbing until reset
        applyStimulus(1, 6'b010101, 1, S_DECODE, 0, 0, 0, "err_fetch");
        applyStimulus(1, 6'b010101, 1, S_ERR,    0, 0, 1, "err_enter");
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 6'(i * 7), 1'(i), S_ERR, 0, 0, 1, "err_hold");
        resetDut("reset_from_err");

        // HALT is absorbing
        applyStimulus(1, OP_HALT, 1, S_DECODE, 0, 0, 0, "halt_fetch");
        applyStimulus(1, OP_HALT, 1, S_HALT,   0, 1, 0, "halt_enter");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, OP_RTYPE, 1'(i), S_HALT, 0, 1, 0, "halt_hold");
        resetDut("reset_from_halt");

        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
